// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
//
// Purpose:
//   Game-flow sequencer for a multi-level obstacle game. It walks through
//   TITLE -> INIT -> PLAY -> DONE/OVER -> ... -> WIN and drives the
//   screen-select flags, the current level index, the elapsed play seconds
//   and the per-block release enables.
//
//   A "request" is a rising edge of i_run or the keycode changing to
//   START_KEY. Both in the same cycle count as one request. A button or key
//   that is held through reset deassertion does not produce a request.
//
// Optional feature:
//   Define LEVEL_SEQUENCER_PAUSE_EN to add a PAUSE state. It is toggled from
//   PLAY by the keycode changing to 8'h13. While paused, the timers and the
//   release schedule freeze, and collisions, end_level and start requests are
//   ignored. Without the macro, keycode 8'h13 has no effect.
//
// Parameters:
//   NUM_LEVELS  number of playable levels (1..15)
//   NUM_BLOCKS  obstacle blocks per level (1..32)
//   CLK_HZ      clock cycles per one-second tick
//   RELEASE_S   seconds between successive block releases (1..63)
//   START_KEY   keycode that starts or advances the game
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_run          push-button, rising edge = request
//   i_keycode      current USB keycode (0 = no key)
//   i_collision    per-player collision flags, level-sensitive
//   i_end_level    per-block "block has left the field" flags
//   o_block_ready  per-block release enables, sticky within a level
//   o_title        title screen select
//   o_pstart       play screen select
//   o_game_over    game-over screen select
//   o_win          win screen select
//   o_level        current level index, 0-based
//   o_seconds      elapsed play seconds in the current level, saturating
// -----------------------------------------------------------------------------
module level_sequencer #(
  parameter int         NUM_LEVELS = 2,
  parameter int         NUM_BLOCKS = 10,
  parameter int         CLK_HZ     = 50000000,
  parameter int         RELEASE_S  = 2,
  parameter logic [7:0] START_KEY  = 8'h28
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_run,
  input  logic [7:0]            i_keycode,
  input  logic [1:0]            i_collision,
  input  logic [NUM_BLOCKS-1:0] i_end_level,
  output logic [NUM_BLOCKS-1:0] o_block_ready,
  output logic                  o_title,
  output logic                  o_pstart,
  output logic                  o_game_over,
  output logic                  o_win,
  output logic [3:0]            o_level,
  output logic [9:0]            o_seconds
);

  localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [5:0]      REL_MAX    = 6'(RELEASE_S - 1);
  localparam logic [3:0]      LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [9:0]      SEC_MAX    = 10'd1023;
  localparam logic [5:0]      BLK_COUNT  = 6'(NUM_BLOCKS);

`ifdef LEVEL_SEQUENCER_PAUSE_EN
  localparam logic [7:0]      PAUSE_KEY  = 8'h13;

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_INIT  = 3'd1,
    S_PLAY  = 3'd2,
    S_DONE  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5,
    S_PAUSE = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_INIT  = 3'd1,
    S_PLAY  = 3'd2,
    S_DONE  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_t;
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic                  r_run_prev;
  logic [7:0]            r_key_prev;
  logic                  r_armed;
  logic [PW-1:0]         r_presc;
  logic [9:0]            r_seconds;
  logic [5:0]            r_rel_cnt;
  logic [5:0]            r_next_blk;
  logic [NUM_BLOCKS-1:0] r_block_ready;
  logic [3:0]            r_level;
  logic                  r_title;
  logic                  r_pstart;
  logic                  r_game_over;
  logic                  r_win;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t                w_state_next;
  logic                  w_run_rise;
  logic                  w_start_rise;
  logic                  w_request;
  logic                  w_collide;
  logic                  w_all_released;
  logic                  w_all_ended;
  logic                  w_complete;
  logic                  w_run_timers;
  logic                  w_tick;
  logic                  w_release;
  logic [NUM_BLOCKS-1:0] w_rel_hit;
  logic [PW-1:0]         w_presc_next;
  logic [9:0]            w_seconds_next;
  logic [5:0]            w_rel_cnt_next;
  logic [5:0]            w_next_blk_next;
  logic [NUM_BLOCKS-1:0] w_block_ready_next;
  logic [3:0]            w_level_next;
  logic                  w_pstart_next;
`ifdef LEVEL_SEQUENCER_PAUSE_EN
  logic                  w_pause_rise;
`endif

  // ---------------------------------------------------------------------------
  // Request detection. r_armed stays low for the first cycle after reset so
  // that a button or key held through reset deassertion (edge registers were
  // cleared to 0) is not mistaken for a fresh press.
  // ---------------------------------------------------------------------------
  assign w_run_rise   = i_run & ~r_run_prev;
  assign w_start_rise = (i_keycode == START_KEY) && (r_key_prev != START_KEY);
  assign w_request    = r_armed & (w_run_rise | w_start_rise);
`ifdef LEVEL_SEQUENCER_PAUSE_EN
  assign w_pause_rise = r_armed && (i_keycode == PAUSE_KEY) && (r_key_prev != PAUSE_KEY);
`endif

  // Level completion only looks at released blocks; end_level of a block
  // still waiting for release is masked off.
  assign w_collide      = |i_collision;
  assign w_all_released = &r_block_ready;
  assign w_all_ended    = &(i_end_level | ~r_block_ready);
  assign w_complete     = w_all_released & w_all_ended;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_TITLE: begin
        if (w_request) w_state_next = S_INIT;
      end
      S_INIT: begin
        w_state_next = S_PLAY;
      end
      S_PLAY: begin
        // Collision wins over completion when both happen together.
        if (w_collide) begin
          w_state_next = S_OVER;
        end else if (w_complete) begin
          w_state_next = S_DONE;
`ifdef LEVEL_SEQUENCER_PAUSE_EN
        end else if (w_pause_rise) begin
          w_state_next = S_PAUSE;
`endif
        end
      end
      S_DONE: begin
        if (w_request) begin
          if (r_level < LAST_LEVEL) w_state_next = S_INIT;
          else                      w_state_next = S_WIN;
        end
      end
      S_OVER, S_WIN: begin
        if (w_request) w_state_next = S_TITLE;
      end
`ifdef LEVEL_SEQUENCER_PAUSE_EN
      S_PAUSE: begin
        if (w_pause_rise) w_state_next = S_PLAY;
      end
`endif
      default: begin
        w_state_next = S_TITLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Timers and release schedule. They only advance while PLAY continues into
  // the next cycle, so seconds freezes on the exact edge that leaves PLAY.
  // ---------------------------------------------------------------------------
  assign w_run_timers = (r_state == S_PLAY) && (w_state_next == S_PLAY);
  assign w_tick       = w_run_timers && (r_presc == PRESC_MAX);
  assign w_release    = w_tick && (r_rel_cnt == REL_MAX);

  // One-hot decode of the next block to release. Block 0 is released on
  // entry to PLAY, so r_next_blk starts at 1.
  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_rel_hit
    assign w_rel_hit[gi] = w_release && (r_next_blk == 6'(gi));
  end

  always_comb begin
    w_presc_next       = r_presc;
    w_seconds_next     = r_seconds;
    w_rel_cnt_next     = r_rel_cnt;
    w_next_blk_next    = r_next_blk;
    w_block_ready_next = r_block_ready;

    if (w_state_next == S_INIT) begin
      w_presc_next       = '0;
      w_seconds_next     = '0;
      w_rel_cnt_next     = '0;
      w_next_blk_next    = 6'd1;
      w_block_ready_next = '0;
    end else if (r_state == S_INIT) begin
      w_block_ready_next = r_block_ready | NUM_BLOCKS'(1);
    end else if (w_run_timers) begin
      w_presc_next = w_tick ? '0 : r_presc + PW'(1);
      if (w_tick) begin
        w_seconds_next = (r_seconds == SEC_MAX) ? r_seconds : r_seconds + 10'd1;
        w_rel_cnt_next = (r_rel_cnt == REL_MAX) ? 6'd0 : r_rel_cnt + 6'd1;
      end
      if (w_release && (r_next_blk < BLK_COUNT)) begin
        w_next_blk_next = r_next_blk + 6'd1;
      end
      w_block_ready_next = r_block_ready | w_rel_hit;
    end
  end

  // Level index: reset to 0 when a new game starts, bumped when advancing.
  always_comb begin
    w_level_next = r_level;
    if ((r_state == S_TITLE) && (w_state_next == S_INIT)) begin
      w_level_next = 4'd0;
    end else if ((r_state == S_DONE) && (w_state_next == S_INIT)) begin
      w_level_next = r_level + 4'd1;
    end
  end

`ifdef LEVEL_SEQUENCER_PAUSE_EN
  assign w_pstart_next = (w_state_next == S_PLAY) || (w_state_next == S_PAUSE);
`else
  assign w_pstart_next = (w_state_next == S_PLAY);
`endif

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_TITLE;
      r_run_prev    <= 1'b0;
      r_key_prev    <= 8'd0;
      r_armed       <= 1'b0;
      r_presc       <= '0;
      r_seconds     <= '0;
      r_rel_cnt     <= '0;
      r_next_blk    <= 6'd1;
      r_block_ready <= '0;
      r_level       <= 4'd0;
      r_title       <= 1'b1;
      r_pstart      <= 1'b0;
      r_game_over   <= 1'b0;
      r_win         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_run_prev    <= i_run;
      r_key_prev    <= i_keycode;
      r_armed       <= 1'b1;
      r_presc       <= w_presc_next;
      r_seconds     <= w_seconds_next;
      r_rel_cnt     <= w_rel_cnt_next;
      r_next_blk    <= w_next_blk_next;
      r_block_ready <= w_block_ready_next;
      r_level       <= w_level_next;
      r_title       <= (w_state_next == S_TITLE);
      r_pstart      <= w_pstart_next;
      r_game_over   <= (w_state_next == S_OVER);
      r_win         <= (w_state_next == S_WIN);
    end
  end

  assign o_block_ready = r_block_ready;
  assign o_title       = r_title;
  assign o_pstart      = r_pstart;
  assign o_game_over   = r_game_over;
  assign o_win         = r_win;
  assign o_level       = r_level;
  assign o_seconds     = r_seconds;

endmodule

// File: tb/tb_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_level_sequencer
//
// Scoreboard bench for level_sequencer with CLK_HZ=10, RELEASE_S=1,
// NUM_BLOCKS=3, NUM_LEVELS=2. The stimulus process drives inputs 1 time unit
// after a rising edge and pushes the expected output snapshot for that cycle
// into a queue. The monitor samples at the falling edge, pops due entries and
// compares. Define LEVEL_SEQUENCER_PAUSE_EN to exercise the PAUSE scenario.
// -----------------------------------------------------------------------------
module tb_level_sequencer;

  localparam int NUM_LEVELS = 2;
  localparam int NUM_BLOCKS = 3;
  localparam int CLK_HZ     = 10;
  localparam int RELEASE_S  = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  run;
  logic [7:0]            keycode;
  logic [1:0]            collision;
  logic [NUM_BLOCKS-1:0] end_level;
  logic [NUM_BLOCKS-1:0] block_ready;
  logic                  title;
  logic                  pstart;
  logic                  game_over;
  logic                  win;
  logic [3:0]            level;
  logic [9:0]            seconds;

  typedef struct packed {
    logic [31:0] cyc;
    logic        title;
    logic        pstart;
    logic        over;
    logic        win;
    logic [3:0]  level;
    logic [9:0]  seconds;
    logic [2:0]  br;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc       = 0;
  int    errors    = 0;
  int    checks    = 0;
  bit    stim_done = 1'b0;

  level_sequencer #(
    .NUM_LEVELS(NUM_LEVELS),
    .NUM_BLOCKS(NUM_BLOCKS),
    .CLK_HZ    (CLK_HZ),
    .RELEASE_S (RELEASE_S),
    .START_KEY (8'h28)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_run        (run),
    .i_keycode    (keycode),
    .i_collision  (collision),
    .i_end_level  (end_level),
    .o_block_ready(block_ready),
    .o_title      (title),
    .o_pstart     (pstart),
    .o_game_over  (game_over),
    .o_win        (win),
    .o_level      (level),
    .o_seconds    (seconds)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected outputs after the most recent rising edge.
  task automatic expect_now(input string nm, input logic t, input logic p,
                            input logic o, input logic w, input logic [3:0] lv,
                            input logic [9:0] s, input logic [2:0] br);
    exp_t e;
    e.cyc     = 32'(cyc);
    e.title   = t;
    e.pstart  = p;
    e.over    = o;
    e.win     = w;
    e.level   = lv;
    e.seconds = s;
    e.br      = br;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t  e;
    exp_t  a;
    string nm;
    int    drain = 0;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.cyc     = 32'(cyc);
        a.title   = title;
        a.pstart  = pstart;
        a.over    = game_over;
        a.win     = win;
        a.level   = level;
        a.seconds = seconds;
        a.br      = block_ready;
        checks++;
        if (int'(e.cyc) != cyc) begin
          errors++;
          $display("FAIL %s: sampled late at cycle %0d, required cycle %0d", nm, cyc, e.cyc);
        end else if (a[21:0] != e[21:0]) begin
          errors++;
          $display("FAIL %s: got t/p/o/w=%b%b%b%b level=%0d sec=%0d br=%b, required t/p/o/w=%b%b%b%b level=%0d sec=%0d br=%b",
                   nm, a.title, a.pstart, a.over, a.win, a.level, a.seconds, a.br,
                   e.title, e.pstart, e.over, e.win, e.level, e.seconds, e.br);
        end else begin
          $display("ok   %s: t/p/o/w=%b%b%b%b level=%0d sec=%0d br=%b",
                   nm, a.title, a.pstart, a.over, a.win, a.level, a.seconds, a.br);
        end
      end
      if (stim_done) begin
        if (exp_q.size() == 0) break;
        drain++;
        if (drain > 10) begin
          errors += exp_q.size();
          checks += exp_q.size();
          $display("FAIL drain: %0d expectations never sampled, required 0", exp_q.size());
          break;
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    reset     = 1'b1;
    run       = 1'b0;
    keycode   = 8'h00;
    collision = 2'b00;
    end_level = 3'b000;
    tick(3);
    reset = 1'b0;
    tick(1);
    expect_now("reset", 1, 0, 0, 0, 4'd0, 10'd0, 3'b000);

    // Start via START_KEY, one INIT cycle, then PLAY with block 0 released.
    keycode = 8'h28;
    tick(1);
    expect_now("init_l0", 0, 0, 0, 0, 4'd0, 10'd0, 3'b000);
    keycode = 8'h00;
    tick(1);
    expect_now("play_c0", 0, 1, 0, 0, 4'd0, 10'd0, 3'b001);
    tick(9);
    expect_now("play_c9", 0, 1, 0, 0, 4'd0, 10'd0, 3'b001);
    tick(1);
    expect_now("play_c10", 0, 1, 0, 0, 4'd0, 10'd1, 3'b011);
    tick(10);
    expect_now("play_c20", 0, 1, 0, 0, 4'd0, 10'd2, 3'b111);

    // Level completion, DONE holds seconds, Run advances to level 1.
    end_level = 3'b111;
    tick(1);
    expect_now("done_l0", 0, 0, 0, 0, 4'd0, 10'd2, 3'b111);
    end_level = 3'b000;
    tick(4);
    expect_now("done_hold", 0, 0, 0, 0, 4'd0, 10'd2, 3'b111);
    run = 1'b1;
    tick(1);
    expect_now("init_l1", 0, 0, 0, 0, 4'd1, 10'd0, 3'b000);
    run = 1'b0;
    tick(1);
    expect_now("play_l1_c0", 0, 1, 0, 0, 4'd1, 10'd0, 3'b001);
    tick(20);
    expect_now("play_l1_c20", 0, 1, 0, 0, 4'd1, 10'd2, 3'b111);
    end_level = 3'b111;
    tick(1);
    expect_now("done_l1", 0, 0, 0, 0, 4'd1, 10'd2, 3'b111);
    end_level = 3'b000;
    run = 1'b1;
    tick(1);
    expect_now("win", 0, 0, 0, 1, 4'd1, 10'd2, 3'b111);
    run = 1'b0;
    tick(2);
    expect_now("win_hold", 0, 0, 0, 1, 4'd1, 10'd2, 3'b111);
    run = 1'b1;
    tick(1);
    expect_now("title_after_win", 1, 0, 0, 0, 4'd1, 10'd2, 3'b111);
    run = 1'b0;

    // Key held from TITLE through OVER; collision beats completion.
    keycode = 8'h28;
    tick(1);
    expect_now("init_held", 0, 0, 0, 0, 4'd0, 10'd0, 3'b000);
    tick(21);
    collision = 2'b10;
    end_level = 3'b111;
    tick(1);
    expect_now("over_priority", 0, 0, 1, 0, 4'd0, 10'd2, 3'b111);
    collision = 2'b00;
    end_level = 3'b000;
    tick(3);
    expect_now("over_held_key", 0, 0, 1, 0, 4'd0, 10'd2, 3'b111);
    keycode = 8'h00;
    run = 1'b1;
    tick(1);
    expect_now("title_after_over", 1, 0, 0, 0, 4'd0, 10'd2, 3'b111);

    // Run held through reset deassertion must not start the game.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    expect_now("rst_run_held", 1, 0, 0, 0, 4'd0, 10'd0, 3'b000);
    tick(2);
    expect_now("rst_run_held2", 1, 0, 0, 0, 4'd0, 10'd0, 3'b000);
    run = 1'b0;
    tick(2);
    expect_now("rst_run_released", 1, 0, 0, 0, 4'd0, 10'd0, 3'b000);
    run = 1'b1;
    tick(1);
    expect_now("init_after_rst", 0, 0, 0, 0, 4'd0, 10'd0, 3'b000);
    run = 1'b0;
    tick(1);
    expect_now("play2_c0", 0, 1, 0, 0, 4'd0, 10'd0, 3'b001);
    tick(10);
    expect_now("play2_c10", 0, 1, 0, 0, 4'd0, 10'd1, 3'b011);

`ifdef LEVEL_SEQUENCER_PAUSE_EN
    keycode = 8'h13;
    tick(1);
    expect_now("pause_enter", 0, 1, 0, 0, 4'd0, 10'd1, 3'b011);
    keycode = 8'h00;
    tick(30);
    expect_now("pause_frozen", 0, 1, 0, 0, 4'd0, 10'd1, 3'b011);
    collision = 2'b01;
    tick(1);
    expect_now("pause_ignore_col", 0, 1, 0, 0, 4'd0, 10'd1, 3'b011);
    collision = 2'b00;
    keycode = 8'h13;
    tick(1);
    expect_now("pause_exit", 0, 1, 0, 0, 4'd0, 10'd1, 3'b011);
    keycode = 8'h00;
    collision = 2'b01;
    tick(1);
    expect_now("over_after_resume", 0, 0, 1, 0, 4'd0, 10'd1, 3'b011);
    collision = 2'b00;
`else
    keycode = 8'h13;
    tick(1);
    expect_now("p_key_no_effect", 0, 1, 0, 0, 4'd0, 10'd1, 3'b011);
    keycode = 8'h00;
    collision = 2'b01;
    tick(1);
    expect_now("over_collision", 0, 0, 1, 0, 4'd0, 10'd1, 3'b011);
    collision = 2'b00;
`endif

    tick(2);
    stim_done = 1'b1;
  end

endmodule
